// File: rtl/button_color_reader_if.sv
// Button/colour signal bundle between the button reader and its consumers.
// The reader uses the slave modport; a pin driver or bench uses master.
interface button_color_reader_if;
  logic       btn_n;
  logic       pressed;
  logic [2:0] color_n;
  logic       color_valid;
  logic       long_press;

  modport master (
    output btn_n,
    input  pressed,
    input  color_n,
    input  color_valid,
    input  long_press
  );

  modport slave (
    input  btn_n,
    output pressed,
    output color_n,
    output color_valid,
    output long_press
  );
endinterface

// File: rtl/button_color_reader.sv
// Synchronizes and debounces an active-low button, then steps an active-low RGB colour code.
// Optional LONG_PRESS_EN: long presses toggle a blank flag that forces the LED off.
module button_color_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000
) (
  input logic                   clk,
  input logic                   rst_n,
  button_color_reader_if.slave  btn_io
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StReleased, StPressed, StHeld} state_e;

  logic           sync1_q, sync2_q;
  logic           deb_q, deb_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           pressed;
  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic           blank_q, blank_d;
  logic [2:0]     color_q, color_d;
  logic           valid_q, valid_d;
  logic           long_q, long_d;
  logic           short_act, long_act;
  logic [2:0]     idx_next;

`ifdef LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_CYCLES);
  logic [HoldW-1:0] hold_q, hold_d;
`endif

  function automatic logic [2:0] color_lut(input logic [2:0] i);
    logic [2:0] c;
    case (i)
      3'd0:    c = 3'b011;
      3'd1:    c = 3'b101;
      3'd2:    c = 3'b110;
      3'd3:    c = 3'b001;
      3'd4:    c = 3'b100;
      3'd5:    c = 3'b010;
      3'd6:    c = 3'b000;
      default: c = 3'b011;
    endcase
    return c;
  endfunction

  // The debounced level only flips after the input has disagreed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    db_cnt_d = '0;
    deb_d    = deb_q;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign pressed  = ~deb_q;
  assign idx_next = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    blank_d   = blank_q;
    valid_d   = 1'b0;
    long_d    = 1'b0;
    short_act = 1'b0;
    long_act  = 1'b0;
`ifdef LONG_PRESS_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      StReleased: begin
        if (pressed) begin
          state_d = StPressed;
`ifdef LONG_PRESS_EN
          hold_d  = '0;
`endif
        end
      end
      StPressed: begin
        // Release is checked first so a coincident long-press threshold loses.
        if (!pressed) begin
          state_d   = StReleased;
          short_act = 1'b1;
        end
`ifdef LONG_PRESS_EN
        else if (hold_q == HoldW'(LONG_CYCLES - 1)) begin
          state_d  = StHeld;
          long_act = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      StHeld: begin
        if (!pressed) state_d = StReleased;
      end
      default: state_d = StReleased;
    endcase

    if (short_act) begin
      valid_d = 1'b1;
`ifdef LONG_PRESS_EN
      if (blank_q) blank_d = 1'b0;
      else         idx_d   = idx_next;
`else
      idx_d = idx_next;
`endif
    end
    if (long_act) begin
      valid_d = 1'b1;
      long_d  = 1'b1;
      blank_d = ~blank_q;
    end
    color_d = blank_d ? 3'b111 : color_lut(idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      deb_q    <= 1'b1;
      db_cnt_q <= '0;
      state_q  <= StReleased;
      idx_q    <= 3'd0;
      color_q  <= 3'b011;
      valid_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_io.btn_n;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      color_q  <= color_d;
      valid_q  <= valid_d;
      long_q   <= long_d;
    end
  end

`ifdef LONG_PRESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      blank_q <= blank_d;
    end
  end
`else
  assign blank_q = 1'b0;
`endif

  assign btn_io.pressed     = pressed;
  assign btn_io.color_n     = color_q;
  assign btn_io.color_valid = valid_q;
  assign btn_io.long_press  = long_q;

endmodule

// File: tb/tb_button_color_reader.sv
// Bench for button_color_reader: press outcomes are predicted from press length alone
// (debounce latency, long threshold, colour sequence) and compared every cycle.
module tb_button_color_reader;

  localparam int Deb  = 4;
  localparam int Long = 20;
`ifdef LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  button_color_reader_if bus ();

  button_color_reader #(
    .DEBOUNCE_CYCLES(Deb),
    .LONG_CYCLES    (Long)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_io(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int m_idx = 0;
  bit m_blank = 1'b0;
  logic [2:0] seq [7] = '{3'b011, 3'b101, 3'b110, 3'b001, 3'b100, 3'b010, 3'b000};

  function automatic logic [2:0] exp_color();
    return m_blank ? 3'b111 : seq[m_idx];
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Must be called just after a negedge; btn_n is held low for n edges, then high.
  task automatic press(input int n, input int tail);
    int  p;
    bit  pr;
    bit  lng;
    bit  v;
    bit  lp;
    p   = Deb + 2;
    pr  = (n >= Deb);
    lng = LongEn && pr && (n >= Long + 1);
    for (int c = 1; c <= n + Deb + tail; c++) begin
      bus.btn_n = (c <= n) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      v  = 1'b0;
      lp = 1'b0;
      if (lng && c == p + Long + 1) begin
        v = 1'b1;
        lp = 1'b1;
        m_blank = !m_blank;
      end
      if (pr && !lng && c == p + n + 1) begin
        v = 1'b1;
        if (m_blank) m_blank = 1'b0;
        else m_idx = (m_idx + 1) % 7;
      end
      chk("pressed", {2'b0, bus.pressed}, {2'b0, (pr && c >= p && c < p + n)});
      chk("color_valid", {2'b0, bus.color_valid}, {2'b0, v});
      chk("long_press", {2'b0, bus.long_press}, {2'b0, lp});
      chk("color_n", bus.color_n, exp_color());
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pressed"}, {2'b0, bus.pressed}, 3'b000);
    chk({tag, "_color_n"}, bus.color_n, 3'b011);
    chk({tag, "_valid"}, {2'b0, bus.color_valid}, 3'b000);
    chk({tag, "_long"}, {2'b0, bus.long_press}, 3'b000);
  endtask

  initial begin
    int n;
    int guard;
    bus.btn_n = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    press(0, 10);         // idle
    press(3, 6);          // glitch shorter than debounce
    press(Deb - 1, 6);
    press(10, 5);         // first short press -> green
    for (int i = 0; i < 6; i++) press(10, 5);   // walk round to red
    press(30, 5);         // long hold
    press(10, 5);
    press(Deb, 5);        // shortest accepted press
    press(Long, 5);       // release coincides with threshold: short
    press(Long + 1, 5);   // just long
    press(10, 5);
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(0, 35);
      press(n, $urandom_range(5, 8));
    end

    guard = 0;
    while (exp_color() != 3'b110 && guard < 20) begin
      press(10, 5);
      guard++;
    end
    chk("reach_blue", bus.color_n, 3'b110);

    bus.btn_n = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("held_before_reset", {2'b0, bus.pressed}, 3'b001);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    m_idx = 0;
    m_blank = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    press(10, 5);         // hold through reset release is a fresh press
    press(10, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
